trace_packet_arbiter: RTL and testbench
=======================================

TRACE_PACKET_ARBITER -- requirements
Module: trace_packet_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: entries per source FIFO.
REQ-002 Parameter PAYLOAD_W, default 23: packet payload width.
REQ-003 mclk  in  1  sole clock; all state updates on posedge mclk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  3  per-source packet offer; bit i = source i; single-cycle, no handshake.
REQ-006 in_type  in  6  source i type at [2i+1:2i].
REQ-007 in_payload  in  69  source i payload at [23i+22:23i].
REQ-008 in_full  out  3  source i FIFO holds DEPTH entries.
REQ-009 out_enable  in  1  sink can accept a packet this cycle.
REQ-010 pkt_type  out  2  granted packet type.
REQ-011 pkt_payload  out  23  granted packet payload.
REQ-012 pkt_strobe  out  1  one-cycle qualifier for pkt_type/pkt_payload.
REQ-013 drop_count  out  16  saturating count of discarded offers.
REQ-014 drop_any  out  1  sticky; set on the first discarded offer.

Function
REQ-015 Each source SHALL own a FIFO of DEPTH {type,payload} entries, pushed when in_valid[i] && !in_full[i].
REQ-016 in_full[i] SHALL come from the registered occupancy only; a pop in the same cycle SHALL NOT free space for a push.
REQ-017 An offer with in_valid[i] && in_full[i] SHALL be discarded and counted; the FIFO contents are unchanged.
REQ-018 drop_count SHALL add the number of sources discarding this cycle (0..3) and saturate at 16'hFFFF.
REQ-019 drop_any SHALL set on any discard and stay set until reset.
REQ-020 With out_enable=1, each cycle SHALL grant at most one non-empty source: source 0 by strict priority, otherwise sources 1/2 by round-robin.
REQ-021 The round-robin pointer SHALL advance only on a grant to source 1 or 2; after reset it favours source 1.
REQ-022 The granted head SHALL pop and be registered to pkt_type/pkt_payload, with pkt_strobe=1 in the following cycle.
REQ-023 Latency into an empty, idle block: offer sampled at edge k, then pkt_strobe high in the cycle after edge k+1 (2 edges).
REQ-024 With out_enable=0 there SHALL be no pops and pkt_strobe=0 next cycle; pushes and drops continue.
REQ-025 When pkt_strobe=0, pkt_type/pkt_payload SHALL hold their last values, never X.
REQ-026 A push to an empty FIFO in the same cycle as arbitration SHALL NOT be granted until the next cycle; there is no bypass.
REQ-027 Per-source order SHALL be preserved; cross-source order follows the grant order only.
REQ-028 Source 0 may starve sources 1/2 indefinitely; this is by design, because trace data outranks status.
REQ-029 Sustained throughput SHALL be one packet per cycle while out_enable=1 and any FIFO is non-empty.

Reset
REQ-030 While reset=1, every FIFO SHALL empty and the outputs SHALL be: in_full=0, pkt_strobe=0, pkt_type=0, pkt_payload=0, drop_count=0, drop_any=0, round-robin pointer=source 1.
REQ-031 Offers present during reset SHALL be ignored, not counted; reset mid-burst discards all queued packets.

Structure
REQ-032 Packet type codes (ADDR=00, READ=01, WRITE=10, TIMESTAMP=11), PAYLOAD_W and the source count SHALL live in the shared trace definitions include.
REQ-033 The per-source queue SHALL be a sub-module, packet_fifo, with push/pop/data/count ports, instantiated three times.

Verification
REQ-034 Single offer: src1 type 10, payload 23'h012345 at edge 5 -> pkt_strobe only in the cycle after edge 6, type 10, payload 23'h012345.
REQ-035 Priority: src0 and src2 both valid at one edge -> src0's packet strobes first and src2's on the next cycle.
REQ-036 Round-robin: src1 and src2 each offer 2 packets with src0 idle -> output order s1,s2,s1,s2.
REQ-037 Overflow: out_enable=0; src0 offers 5 packets -> in_full[0]=1 after 2; drop_count=3; drop_any=1; with out_enable=1 the first 2 packets emerge in order.
REQ-038 Saturation: preload drop_count=16'hFFFE; all three sources drop in one cycle -> drop_count=16'hFFFF.
REQ-039 Reset mid-operation: 2 queued per source, assert reset for one cycle -> no strobes afterward, all counters 0, and a new offer follows REQ-023 latency.

Source files
------------

// File: rtl/trace_packet_arbiter_pkg.sv
// rtl/trace_packet_arbiter_pkg.sv - shared trace packet definitions
package trace_packet_arbiter_pkg;

  localparam int TRACE_NUM_SRC   = 3;
  localparam int TRACE_TYPE_W    = 2;
  localparam int TRACE_PAYLOAD_W = 23;

  typedef enum logic [TRACE_TYPE_W-1:0] {
    PKT_ADDR      = 2'b00,
    PKT_READ      = 2'b01,
    PKT_WRITE     = 2'b10,
    PKT_TIMESTAMP = 2'b11
  } pkt_type_e;

  // Number of sources discarding an offer in one cycle (0..3).
  function automatic logic [1:0] count_ones3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/packet_fifo.sv
// rtl/packet_fifo.sv - per-source circular packet queue
module packet_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 25,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage; caller only pushes when not full, so no guard here.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_tail] <= push_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= next_ptr(r_tail);
      if (pop)  r_head <= next_ptr(r_head);
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_head];
  assign count    = r_count;

endmodule

// File: rtl/trace_packet_arbiter.sv
// rtl/trace_packet_arbiter.sv - three-source trace packet arbiter with drop accounting
module trace_packet_arbiter
  import trace_packet_arbiter_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = TRACE_PAYLOAD_W
) (
  input  logic                               mclk,
  input  logic                               reset,
  input  logic [TRACE_NUM_SRC-1:0]           in_valid,
  input  logic [TRACE_NUM_SRC*TRACE_TYPE_W-1:0] in_type,
  input  logic [TRACE_NUM_SRC*PAYLOAD_W-1:0] in_payload,
  output logic [TRACE_NUM_SRC-1:0]           in_full,
  input  logic                               out_enable,
  output logic [TRACE_TYPE_W-1:0]            pkt_type,
  output logic [PAYLOAD_W-1:0]               pkt_payload,
  output logic                               pkt_strobe,
  output logic [15:0]                        drop_count,
  output logic                               drop_any
);

  localparam int ENTRY_W = TRACE_TYPE_W + PAYLOAD_W;
  localparam int CW      = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0]       w_fifo_data  [TRACE_NUM_SRC];
  logic [CW-1:0]            w_fifo_count [TRACE_NUM_SRC];
  logic [TRACE_NUM_SRC-1:0] w_push;
  logic [TRACE_NUM_SRC-1:0] w_drop;
  logic [TRACE_NUM_SRC-1:0] w_nonempty;
  logic [TRACE_NUM_SRC-1:0] w_grant;
  logic [ENTRY_W-1:0]       w_grant_data;
  logic [16:0]              w_drop_sum;

  logic                     r_rr_pick2;
  logic                     r_pkt_strobe;
  logic [TRACE_TYPE_W-1:0]  r_pkt_type;
  logic [PAYLOAD_W-1:0]     r_pkt_payload;
  logic [15:0]              r_drop_count;
  logic                     r_drop_any;

  for (genvar i = 0; i < TRACE_NUM_SRC; i++) begin : g_src
    // Full and empty come from registered occupancy, so a same-cycle pop
    // never frees room and a same-cycle push is never granted.
    assign in_full[i]    = (w_fifo_count[i] == CW'(DEPTH));
    assign w_nonempty[i] = (w_fifo_count[i] != '0);
    assign w_push[i]     = in_valid[i] && !in_full[i];
    assign w_drop[i]     = in_valid[i] && in_full[i];

    packet_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
    ) u_fifo (
      .clk       (mclk),
      .reset     (reset),
      .push      (w_push[i]),
      .push_data ({in_type[TRACE_TYPE_W*i +: TRACE_TYPE_W], in_payload[PAYLOAD_W*i +: PAYLOAD_W]}),
      .pop       (w_grant[i]),
      .pop_data  (w_fifo_data[i]),
      .count     (w_fifo_count[i])
    );
  end

  // Source 0 wins outright; sources 1 and 2 share by round-robin.
  always_comb begin
    w_grant = '0;
    if (out_enable) begin
      if (w_nonempty[0])                       w_grant = 3'b001;
      else if (w_nonempty[1] && w_nonempty[2]) w_grant = r_rr_pick2 ? 3'b100 : 3'b010;
      else if (w_nonempty[1])                  w_grant = 3'b010;
      else if (w_nonempty[2])                  w_grant = 3'b100;
    end
  end

  // Head of the granted queue.
  always_comb begin
    w_grant_data = w_fifo_data[2];
    if (w_grant[0])      w_grant_data = w_fifo_data[0];
    else if (w_grant[1]) w_grant_data = w_fifo_data[1];
  end

  assign w_drop_sum = {1'b0, r_drop_count} + 17'(count_ones3(w_drop));

  // Round-robin pointer moves only when source 1 or 2 is served.
  always_ff @(posedge mclk) begin
    if (reset)           r_rr_pick2 <= 1'b0;
    else if (w_grant[1]) r_rr_pick2 <= 1'b1;
    else if (w_grant[2]) r_rr_pick2 <= 1'b0;
  end

  // Output register: load on grant, otherwise hold last packet.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_pkt_strobe  <= 1'b0;
      r_pkt_type    <= '0;
      r_pkt_payload <= '0;
    end else begin
      r_pkt_strobe <= |w_grant;
      if (|w_grant) {r_pkt_type, r_pkt_payload} <= w_grant_data;
    end
  end

  // Saturating drop counter and sticky drop flag.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_drop_count <= '0;
      r_drop_any   <= 1'b0;
    end else begin
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      if (|w_drop) r_drop_any <= 1'b1;
    end
  end

  assign pkt_strobe  = r_pkt_strobe;
  assign pkt_type    = r_pkt_type;
  assign pkt_payload = r_pkt_payload;
  assign drop_count  = r_drop_count;
  assign drop_any    = r_drop_any;

endmodule

// File: tb/tb_trace_packet_arbiter.sv
// tb/tb_trace_packet_arbiter.sv - directed self-checking bench for trace_packet_arbiter
module tb_trace_packet_arbiter;
  import trace_packet_arbiter_pkg::*;

  logic        mclk = 1'b0;
  logic        reset;
  logic [2:0]  in_valid;
  logic [5:0]  in_type;
  logic [68:0] in_payload;
  logic [2:0]  in_full;
  logic        out_enable;
  logic [1:0]  pkt_type;
  logic [22:0] pkt_payload;
  logic        pkt_strobe;
  logic [15:0] drop_count;
  logic        drop_any;

  int n_checks = 0;
  int n_errors = 0;

  trace_packet_arbiter dut (
    .mclk        (mclk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_type     (in_type),
    .in_payload  (in_payload),
    .in_full     (in_full),
    .out_enable  (out_enable),
    .pkt_type    (pkt_type),
    .pkt_payload (pkt_payload),
    .pkt_strobe  (pkt_strobe),
    .drop_count  (drop_count),
    .drop_any    (drop_any)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input int src, input logic [1:0] t, input logic [22:0] p);
    in_valid[src]          = 1'b1;
    in_type[2*src +: 2]    = t;
    in_payload[23*src +: 23] = p;
  endtask

  task automatic chk_pkt(input string tag, input logic [1:0] t, input logic [22:0] p);
    chk({tag, "_strobe"}, 32'(pkt_strobe), 32'd1);
    chk({tag, "_type"}, 32'(pkt_type), 32'(t));
    chk({tag, "_payload"}, 32'(pkt_payload), 32'(p));
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 3'b111;
    in_type    = '1;
    in_payload = '1;
    out_enable = 1'b1;

    // Reset with offers present: offers ignored.
    tick(); tick();
    chk("rst_full", 32'(in_full), 32'd0);
    chk("rst_strobe", 32'(pkt_strobe), 32'd0);
    chk("rst_type", 32'(pkt_type), 32'd0);
    chk("rst_payload", 32'(pkt_payload), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_drop_any", 32'(drop_any), 32'd0);
    reset    = 1'b0;
    in_valid = '0;
    tick();
    chk("post_rst_full", 32'(in_full), 32'd0);
    chk("post_rst_strobe", 32'(pkt_strobe), 32'd0);

    // Single offer: two-edge latency.
    offer(1, PKT_WRITE, 23'h012345);
    tick();
    in_valid = '0;
    chk("single_early", 32'(pkt_strobe), 32'd0);
    tick();
    chk_pkt("single", PKT_WRITE, 23'h012345);
    tick();
    chk("single_after", 32'(pkt_strobe), 32'd0);
    chk("single_hold", 32'(pkt_payload), 32'h012345);

    // Priority: src0 beats src2.
    offer(0, PKT_ADDR, 23'h000111);
    offer(2, PKT_TIMESTAMP, 23'h000333);
    tick();
    in_valid = '0;
    chk("prio_early", 32'(pkt_strobe), 32'd0);
    tick();
    chk_pkt("prio_first", PKT_ADDR, 23'h000111);
    tick();
    chk_pkt("prio_second", PKT_TIMESTAMP, 23'h000333);
    tick();
    chk("prio_after", 32'(pkt_strobe), 32'd0);

    // Round-robin between src1 and src2; pointer favours src1 here.
    offer(1, PKT_READ, 23'h000101);
    offer(2, PKT_READ, 23'h000201);
    tick();
    offer(1, PKT_READ, 23'h000102);
    offer(2, PKT_READ, 23'h000202);
    tick();
    in_valid = '0;
    chk_pkt("rr_1", PKT_READ, 23'h000101);
    chk("rr_full", 32'(in_full), 32'b100);
    tick();
    chk_pkt("rr_2", PKT_READ, 23'h000201);
    tick();
    chk_pkt("rr_3", PKT_READ, 23'h000102);
    tick();
    chk_pkt("rr_4", PKT_READ, 23'h000202);
    tick();
    chk("rr_after", 32'(pkt_strobe), 32'd0);

    // Overflow with output stalled.
    out_enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      offer(0, PKT_READ, 23'h000501 + 23'(k));
      tick();
      if (k == 0) chk("ovf_full_after1", 32'(in_full), 32'b000);
      if (k == 1) begin
        chk("ovf_full_after2", 32'(in_full), 32'b001);
        chk("ovf_no_drop_yet", 32'(drop_any), 32'd0);
      end
      chk("ovf_stalled_strobe", 32'(pkt_strobe), 32'd0);
    end
    chk("ovf_drop_count", 32'(drop_count), 32'd3);
    chk("ovf_drop_any", 32'(drop_any), 32'd1);
    // Pop and push in the same cycle: push still dropped.
    out_enable = 1'b1;
    offer(0, PKT_READ, 23'h000506);
    tick();
    in_valid = '0;
    chk_pkt("ovf_out1", PKT_READ, 23'h000501);
    chk("ovf_same_cycle_drop", 32'(drop_count), 32'd4);
    chk("ovf_full_cleared", 32'(in_full), 32'b000);
    tick();
    chk_pkt("ovf_out2", PKT_READ, 23'h000502);
    tick();
    chk("ovf_after", 32'(pkt_strobe), 32'd0);

    // Reset mid-operation.
    out_enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      offer(0, PKT_ADDR, 23'h000600 + 23'(k));
      offer(1, PKT_READ, 23'h000610 + 23'(k));
      offer(2, PKT_WRITE, 23'h000620 + 23'(k));
      tick();
    end
    in_valid = '0;
    chk("mid_full", 32'(in_full), 32'b111);
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    out_enable = 1'b1;
    chk("mid_full_rst", 32'(in_full), 32'd0);
    chk("mid_drop_count", 32'(drop_count), 32'd0);
    chk("mid_drop_any", 32'(drop_any), 32'd0);
    chk("mid_payload", 32'(pkt_payload), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_no_strobe", 32'(pkt_strobe), 32'd0);
    end
    offer(2, PKT_TIMESTAMP, 23'h07ABCD);
    tick();
    in_valid = '0;
    chk("mid_new_early", 32'(pkt_strobe), 32'd0);
    tick();
    chk_pkt("mid_new", PKT_TIMESTAMP, 23'h07ABCD);
    tick();

    // Saturation: fill all three, then drive drop_count to FFFE and beyond.
    out_enable = 1'b0;
    offer(0, PKT_ADDR, 23'h1);
    offer(1, PKT_ADDR, 23'h2);
    offer(2, PKT_ADDR, 23'h3);
    tick(); tick();
    chk("sat_no_drop_fill", 32'(drop_count), 32'd0);
    for (int k = 0; k < 21844; k++) tick();
    chk("sat_65532", 32'(drop_count), 32'd65532);
    in_valid = 3'b011;
    tick();
    chk("sat_fffe", 32'(drop_count), 32'h0000FFFE);
    in_valid = 3'b111;
    tick();
    chk("sat_ffff", 32'(drop_count), 32'h0000FFFF);
    tick();
    chk("sat_hold", 32'(drop_count), 32'h0000FFFF);
    in_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
